// File: rtl/l2_tcdm_responder.sv
// TCDM slave front-end for a single-port L2 SRAM bank: decodes the window, forwards accesses,
// and returns one response per grant after a fixed latency, with sticky out-of-range error capture.
module l2_tcdm_responder #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           MEM_ADDR_WIDTH = 14,
    parameter int unsigned           MEM_LATENCY    = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1C00_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      req_i,
    input  logic [ADDR_WIDTH-1:0]     add_i,
    input  logic                      wen_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_o,

    output logic                      mem_csn_o,
    output logic                      mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

    input  logic                      stall_i,
    input  logic                      err_clr_i,
    output logic                      err_o,
    output logic [ADDR_WIDTH-1:0]     err_addr_o,
    output logic [2:0]                outstanding_o
);

    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5);
    localparam logic [ADDR_WIDTH:0]   SPAN      = {{(ADDR_WIDTH-MEM_ADDR_WIDTH-2){1'b0}}, 1'b1,
                                                   {(MEM_ADDR_WIDTH+2){1'b0}}};

    typedef struct packed {
        logic valid;
        logic is_read;
        logic is_err;
    } stage_t;

    logic                  grant;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] offset;
    stage_t                pipe_q [MEM_LATENCY];
    stage_t                resp;
    logic [2:0]            outstanding_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    // Reset gates the grant so nothing is accepted while the pipeline is being cleared.
    assign grant    = req_i & ~stall_i & rst_ni;
    assign offset   = add_i - BASE_ADDR;
    assign in_range = (add_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);

    assign gnt_o       = grant;
    assign mem_csn_o   = ~(grant & in_range);
    assign mem_wen_o   = wen_i;
    assign mem_addr_o  = offset[MEM_ADDR_WIDTH+1:2];
    assign mem_wdata_o = wdata_i;
    assign mem_be_o    = be_i;

    // Fixed-latency response tracker; it never stalls, so responses stay aligned with SRAM data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < MEM_LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: grant, is_read: grant & wen_i, is_err: grant & ~in_range};
            for (int k = MEM_LATENCY - 1; k > 0; k--) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign resp      = pipe_q[MEM_LATENCY-1];
    assign r_valid_o = resp.valid;

    always_comb begin
        r_rdata_o = '0;
        if (resp.valid) begin
            if (resp.is_err) begin
                r_rdata_o = ERR_RDATA;
            end else if (resp.is_read) begin
                r_rdata_o = mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= 3'd0;
        end else begin
            case ({grant, resp.valid})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign outstanding_o = outstanding_q;

    // A new fault outranks a simultaneous clear, and re-arms the address capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (grant && !in_range) begin
            err_q <= 1'b1;
            if (!err_q || err_clr_i) begin
                err_addr_q <= add_i;
            end
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Drives three responder instances (latency 1, 2, 3) with the same traffic and compares each
// against a cycle-level reference model of the TCDM response protocol.
module tb_l2_tcdm_responder;

    localparam logic [31:0] BASE      = 32'h1C00_0000;
    localparam int          MEM_WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic        err_clr;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] initWord(input int unsigned w);
        return 32'hA500_0000 | w;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] b);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) res[i*8 +: 8] = nw[i*8 +: 8];
        end
        return res;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = g + 1;

        logic        gnt, r_valid, mem_csn, mem_wen, err;
        logic [31:0] r_rdata, mem_wdata, mem_rdata, err_addr;
        logic [13:0] mem_addr;
        logic [3:0]  mem_be;
        logic [2:0]  outstanding;

        l2_tcdm_responder #(
            .ADDR_WIDTH    (32),
            .DATA_WIDTH    (32),
            .MEM_ADDR_WIDTH(14),
            .MEM_LATENCY   (L),
            .BASE_ADDR     (BASE)
        ) dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .req_i        (req),
            .add_i        (add),
            .wen_i        (wen),
            .wdata_i      (wdata),
            .be_i         (be),
            .gnt_o        (gnt),
            .r_valid_o    (r_valid),
            .r_rdata_o    (r_rdata),
            .mem_csn_o    (mem_csn),
            .mem_wen_o    (mem_wen),
            .mem_addr_o   (mem_addr),
            .mem_wdata_o  (mem_wdata),
            .mem_be_o     (mem_be),
            .mem_rdata_i  (mem_rdata),
            .stall_i      (stall),
            .err_clr_i    (err_clr),
            .err_o        (err),
            .err_addr_o   (err_addr),
            .outstanding_o(outstanding)
        );

        // SRAM stand-in: data appears L cycles after select, garbage otherwise.
        logic [31:0] sram    [MEM_WORDS];
        bit          written [MEM_WORDS];
        logic [31:0] rdPipe  [L];

        always @(posedge clk) begin
            for (int k = L - 1; k > 0; k--) rdPipe[k] <= rdPipe[k-1];
            rdPipe[0] <= $urandom;
            if (!mem_csn) begin
                if (mem_wen) begin
                    rdPipe[0] <= written[mem_addr] ? sram[mem_addr] : initWord(32'(mem_addr));
                end else begin
                    sram[mem_addr]    <= mergeBytes(written[mem_addr] ? sram[mem_addr]
                                                    : initWord(32'(mem_addr)), mem_wdata, mem_be);
                    written[mem_addr] <= 1'b1;
                end
            end
        end

        assign mem_rdata = rdPipe[L-1];

        // Reference model: a schedule of due responses indexed by cycles-from-now.
        initial begin : model
            bit          expValid [8];
            logic [31:0] expData  [8];
            logic [31:0] memModel [int unsigned];
            bit          errExp;
            logic [31:0] errAddrExp;
            int          pending;
            bit          granted;
            bit          inRange;
            longint      a;
            int unsigned word;
            logic [31:0] cur;
            string       p;
            p = $sformatf("L%0d", L);
            errExp     = 1'b0;
            errAddrExp = '0;
            for (int i = 0; i < 8; i++) expValid[i] = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    checkOutput({p, " rst gnt"},         32'(gnt),         32'd0);
                    checkOutput({p, " rst r_valid"},     32'(r_valid),     32'd0);
                    checkOutput({p, " rst r_rdata"},     r_rdata,          32'd0);
                    checkOutput({p, " rst mem_csn"},     32'(mem_csn),     32'd1);
                    checkOutput({p, " rst err"},         32'(err),         32'd0);
                    checkOutput({p, " rst err_addr"},    err_addr,         32'd0);
                    checkOutput({p, " rst outstanding"}, 32'(outstanding), 32'd0);
                    for (int i = 0; i < 8; i++) expValid[i] = 1'b0;
                    errExp     = 1'b0;
                    errAddrExp = '0;
                    continue;
                end
                pending = 0;
                for (int i = 0; i < 8; i++) pending += int'(expValid[i]);
                checkOutput({p, " outstanding"}, 32'(outstanding), 32'(pending));
                checkOutput({p, " r_valid"},     32'(r_valid),     32'(expValid[0]));
                checkOutput({p, " r_rdata"},     r_rdata,          expValid[0] ? expData[0] : 32'd0);
                checkOutput({p, " err"},         32'(err),         32'(errExp));
                checkOutput({p, " err_addr"},    err_addr,         errAddrExp);

                granted = req && !stall;
                a       = longint'(add);
                inRange = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * MEM_WORDS);
                word    = int'((a - longint'(BASE)) / 4);
                checkOutput({p, " gnt"},     32'(gnt),     32'(granted));
                checkOutput({p, " mem_csn"}, 32'(mem_csn), 32'(!(granted && inRange)));
                if (granted && inRange) begin
                    checkOutput({p, " mem_addr"},  32'(mem_addr), word);
                    checkOutput({p, " mem_wen"},   32'(mem_wen),  32'(wen));
                    checkOutput({p, " mem_be"},    32'(mem_be),   32'(be));
                    checkOutput({p, " mem_wdata"}, mem_wdata,     wdata);
                end

                for (int i = 0; i < 7; i++) begin
                    expValid[i] = expValid[i+1];
                    expData[i]  = expData[i+1];
                end
                expValid[7] = 1'b0;

                if (granted) begin
                    cur = memModel.exists(word) ? memModel[word] : initWord(word);
                    expValid[L-1] = 1'b1;
                    expData[L-1]  = !inRange ? 32'hBADACCE5 : (wen ? cur : 32'd0);
                    if (inRange && !wen) memModel[word] = mergeBytes(cur, wdata, be);
                end

                if (granted && !inRange) begin
                    if (!errExp || err_clr) errAddrExp = add;
                    errExp = 1'b1;
                end else if (err_clr) begin
                    errExp = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input bit r, input logic [31:0] a, input bit w, input logic [31:0] d,
                                 input logic [3:0] b, input bit s, input bit c);
        req     = r;
        add     = a;
        wen     = w;
        wdata   = d;
        be      = b;
        stall   = s;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b1, 32'd0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        int          kind;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Write then read back one word.
        applyStimulus(1'b1, 32'h1C00_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1C00_0010, 1'b1, 32'd0,        4'hF, 1'b0, 1'b0);
        idle(4);

        // Eight back-to-back reads.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, BASE + 32'(i * 4), 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        idle(4);

        // Stall with a request held and a response still in flight.
        applyStimulus(1'b1, BASE + 32'h8, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b1, BASE + 32'hC, 1'b1, 32'd0, 4'hF, 1'b1, 1'b0);
        applyStimulus(1'b1, BASE + 32'hC, 1'b1, 32'd0, 4'hF, 1'b1, 1'b0);
        applyStimulus(1'b1, BASE + 32'hC, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        idle(4);

        // Partial byte write, then the last word of the window.
        applyStimulus(1'b1, BASE + 32'h20,   1'b0, 32'h1234_5678, 4'b0010, 1'b0, 1'b0);
        applyStimulus(1'b1, BASE + 32'h20,   1'b1, 32'd0,         4'hF,    1'b0, 1'b0);
        applyStimulus(1'b1, BASE + 32'hFFFC, 1'b0, 32'hCAFE_F00D, 4'hF,    1'b0, 1'b0);
        applyStimulus(1'b1, BASE + 32'hFFFC, 1'b1, 32'd0,         4'hF,    1'b0, 1'b0);
        idle(4);

        // Error capture, second error, then clear coinciding with a third error.
        applyStimulus(1'b1, 32'h1C01_0000, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b1, 32'h1C02_0000, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b1, 32'h1BFF_FFFC, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1);
        idle(4);
        applyStimulus(1'b0, 32'd0, 1'b1, 32'd0, 4'hF, 1'b0, 1'b1);
        idle(2);

        // Reset one cycle after a grant, with the request held through reset.
        applyStimulus(1'b1, BASE + 32'h4, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b1, BASE + 32'h4, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b1, BASE + 32'h4, 1'b1, 32'd0, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0:       ra = BASE - 32'd4;
                1:       ra = $urandom;
                2:       ra = BASE + 32'h0001_0000 + 32'($urandom_range(0, 255));
                3:       ra = BASE + 32'hFFFC + 32'($urandom_range(0, 3));
                default: ra = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
            endcase
            applyStimulus($urandom_range(0, 9) < 7, ra, 1'($urandom), $urandom, 4'($urandom),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/l2_tcdm_responder.md
L2_TCDM_RESPONDER -- requirements
Module: l2_tcdm_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, TCDM byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; BE width = DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 14, SRAM word-address width.
REQ-004 SHALL have parameter MEM_LATENCY, default 1, SRAM read latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h1C00_0000, first byte address served.
REQ-006 SHALL have ports, in order: clk_i in 1 clock; rst_ni in 1 reset. One clock domain; reset is asynchronous and active-low.
REQ-007 SHALL have TCDM slave ports: req_i in 1 request; add_i in ADDR_WIDTH byte address; wen_i in 1 (1 = read, 0 = write); wdata_i in DATA_WIDTH; be_i in DATA_WIDTH/8; gnt_o out 1; r_valid_o out 1; r_rdata_o out DATA_WIDTH.
REQ-008 SHALL have SRAM ports: mem_csn_o out 1 active-low select; mem_wen_o out 1 (1 = read); mem_addr_o out MEM_ADDR_WIDTH; mem_wdata_o out DATA_WIDTH; mem_be_o out DATA_WIDTH/8; mem_rdata_i in DATA_WIDTH, valid MEM_LATENCY cycles after select.
REQ-009 SHALL have control ports: stall_i in 1 (blocks new grants); err_clr_i in 1 clears error; err_o out 1 sticky error; err_addr_o out ADDR_WIDTH first faulting address; outstanding_o out 3 in-flight count.

Function
REQ-010 SHALL assert gnt_o combinationally as req_i & ~stall_i; there is no other grant throttling.
REQ-011 SHALL treat a granted request as in range when BASE_ADDR <= add_i < BASE_ADDR + 4*2^MEM_ADDR_WIDTH.
REQ-012 SHALL, for an in-range grant, drive mem_csn_o=0, mem_addr_o=(add_i-BASE_ADDR)>>2, and pass wen_i, wdata_i and be_i through in the same cycle; otherwise mem_csn_o=1.
REQ-013 SHALL assert r_valid_o for exactly one cycle, exactly MEM_LATENCY cycles after each grant cycle, for both reads and writes.
REQ-014 SHALL implement REQ-013 with a MEM_LATENCY-stage shift register carrying {valid, is_read, is_err} per stage, advancing every cycle and never stalling.
REQ-015 SHALL drive r_rdata_o = mem_rdata_i for an in-range read response, 0 for a write response, 32'hBADACCE5 for an out-of-range response, and 0 whenever r_valid_o=0.
REQ-016 SHALL grant out-of-range requests, leave the SRAM unselected, and respond per REQ-013 and REQ-015.
REQ-017 SHALL set err_o on the first out-of-range grant and capture add_i into err_addr_o; later errors leave err_addr_o unchanged while err_o=1.
REQ-018 SHALL clear err_o on err_clr_i; when err_clr_i coincides with a new error, the set wins and err_addr_o takes the new address.
REQ-019 SHALL support back-to-back grants every cycle, giving one response per cycle in grant order.
REQ-020 SHALL let stall_i block only new grants; in-flight responses still complete.
REQ-021 SHALL update outstanding_o as +1 per grant and -1 per response; a simultaneous grant and response leaves it unchanged; the maximum is MEM_LATENCY.

Reset
REQ-022 SHALL, while rst_ni=0, hold gnt_o=0, r_valid_o=0, r_rdata_o=0, mem_csn_o=1, err_o=0, err_addr_o=0 and outstanding_o=0, and clear all pipeline stages.
REQ-023 SHALL discard in-flight requests on reset assertion; no r_valid_o is produced for them after reset releases.

Verification
REQ-024 Read, MEM_LATENCY=1: write 0xDEADBEEF to 0x1C000010 with be=4'hF, then read it -> mem_addr_o=4 on both; write r_valid_o one cycle after grant with rdata 0; read r_valid_o one cycle after grant with rdata 0xDEADBEEF.
REQ-025 Streaming, MEM_LATENCY=3: 8 back-to-back reads -> 8 gnt_o cycles; r_valid_o high for 8 consecutive cycles starting 3 cycles after the first grant; data in order; outstanding_o peaks at 3.
REQ-026 Stall: stall_i=1 for 2 cycles with req_i held -> gnt_o=0 for those cycles; the pending response still arrives; the request is granted on the first cycle after stall_i drops.
REQ-027 Error: read 0x1C010000 with MEM_ADDR_WIDTH=14 -> mem_csn_o stays 1; rdata 0xBADACCE5; err_o=1; err_addr_o=0x1C010000. A second bad address does not change err_addr_o. err_clr_i together with a third error -> err_o stays 1 and err_addr_o takes the third address.
REQ-028 Reset mid-flight, MEM_LATENCY=2: assert rst_ni=0 one cycle after a grant -> no r_valid_o during or after reset; outstanding_o=0.
REQ-029 Byte enables: write be=4'b0010 -> mem_be_o=4'b0010 in the grant cycle.
